// File: rtl/alu4_pkg.sv
// Shared definitions for the alu4 command sequencer: state encoding, opcode width
// and flag bit positions inside the {c,n,z,v} flag vector.
package alu4_pkg;

  localparam int unsigned OpW = 3;

  localparam int unsigned FlagC = 3;
  localparam int unsigned FlagN = 2;
  localparam int unsigned FlagZ = 1;
  localparam int unsigned FlagV = 0;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StIssue = 2'd1,
    StResp  = 2'd2
  } state_e;

endpackage

// File: rtl/alu4_cmd_seq_if.sv
// Command, response and alu4 connection bundle for the sequencer.
// master = command source / response sink / alu4 side, slave = the sequencer.
interface alu4_cmd_seq_if #(
  parameter int unsigned WIDTH = 4
);
  import alu4_pkg::*;

  logic             cmd_valid;
  logic             cmd_ready;
  logic             cmd_load;
  logic [OpW-1:0]   cmd_op;
  logic [1:0]       cmd_rd;
  logic [1:0]       cmd_ra;
  logic [1:0]       cmd_rb;
  logic             cmd_imm_en;
  logic [WIDTH-1:0] cmd_imm;

  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [OpW-1:0]   alu_op;
  logic [WIDTH-1:0] alu_result;
  logic             alu_c;
  logic             alu_n;
  logic             alu_z;
  logic             alu_v;

  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_result;
  logic [3:0]       rsp_flags;

  logic             busy;

  modport slave (
    input  cmd_valid, cmd_load, cmd_op, cmd_rd, cmd_ra, cmd_rb, cmd_imm_en, cmd_imm,
    input  alu_result, alu_c, alu_n, alu_z, alu_v,
    input  rsp_ready,
    output cmd_ready, alu_a, alu_b, alu_op, rsp_valid, rsp_result, rsp_flags, busy
  );

  modport master (
    output cmd_valid, cmd_load, cmd_op, cmd_rd, cmd_ra, cmd_rb, cmd_imm_en, cmd_imm,
    output alu_result, alu_c, alu_n, alu_z, alu_v,
    output rsp_ready,
    input  cmd_ready, alu_a, alu_b, alu_op, rsp_valid, rsp_result, rsp_flags, busy
  );

endinterface

// File: rtl/alu4_regfile.sv
// 4-entry operand register file: two combinational read ports, one synchronous
// write port, asynchronously cleared by reset.
module alu4_regfile #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we,
  input  logic [1:0]       waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [1:0]       raddr_a,
  input  logic [1:0]       raddr_b,
  output logic [WIDTH-1:0] rdata_a,
  output logic [WIDTH-1:0] rdata_b
);

  logic [WIDTH-1:0] mem [4];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata_a = mem[raddr_a];
  assign rdata_b = mem[raddr_b];

endmodule

// File: rtl/alu4_cmd_seq.sv
// Command sequencer driving an external combinational alu4: one command in flight,
// operands sampled at acceptance, result and flags captured after SETTLE cycles.
module alu4_cmd_seq
  import alu4_pkg::*;
#(
  parameter int unsigned WIDTH  = 4,
  parameter int unsigned SETTLE = 1
) (
  input  logic          clk,
  input  logic          reset,
  alu4_cmd_seq_if.slave bus
);

  localparam logic [3:0] SettleInit = 4'(SETTLE - 1);

  state_e           state;
  logic [3:0]       cnt;
  logic [1:0]       rd_q;
  logic [WIDTH-1:0] alu_a_q;
  logic [WIDTH-1:0] alu_b_q;
  logic [OpW-1:0]   alu_op_q;
  logic [WIDTH-1:0] rsp_result_q;
  logic [3:0]       rsp_flags_q;

  logic             accept;
  logic             capture;
  logic             rf_we;
  logic [1:0]       rf_waddr;
  logic [WIDTH-1:0] rf_wdata;
  logic [WIDTH-1:0] rf_a;
  logic [WIDTH-1:0] rf_b;

  assign accept  = bus.cmd_valid && (state == StIdle);
  assign capture = (state == StIssue) && (cnt == 4'd0);

  // Loads write from the command bus in IDLE; ALU results write from the latched rd.
  always_comb begin
    rf_we    = (accept && bus.cmd_load) || capture;
    rf_waddr = rd_q;
    rf_wdata = bus.alu_result;
    if (state == StIdle) begin
      rf_waddr = bus.cmd_rd;
      rf_wdata = bus.cmd_imm;
    end
  end

  alu4_regfile #(
    .WIDTH(WIDTH)
  ) u_regfile (
    .clk    (clk),
    .reset  (reset),
    .we     (rf_we),
    .waddr  (rf_waddr),
    .wdata  (rf_wdata),
    .raddr_a(bus.cmd_ra),
    .raddr_b(bus.cmd_rb),
    .rdata_a(rf_a),
    .rdata_b(rf_b)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= StIdle;
      cnt          <= 4'd0;
      rd_q         <= 2'd0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_op_q     <= '0;
      rsp_result_q <= '0;
      rsp_flags_q  <= 4'd0;
    end else begin
      unique case (state)
        StIdle: begin
          if (accept) begin
            if (bus.cmd_load) begin
              rsp_result_q <= bus.cmd_imm;
              rsp_flags_q  <= 4'd0;
              state        <= StResp;
            end else begin
              alu_a_q  <= rf_a;
              alu_b_q  <= bus.cmd_imm_en ? bus.cmd_imm : rf_b;
              alu_op_q <= bus.cmd_op;
              rd_q     <= bus.cmd_rd;
              cnt      <= SettleInit;
              state    <= StIssue;
            end
          end
        end
        StIssue: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            rsp_result_q       <= bus.alu_result;
            rsp_flags_q[FlagC] <= bus.alu_c;
            rsp_flags_q[FlagN] <= bus.alu_n;
            rsp_flags_q[FlagZ] <= bus.alu_z;
            rsp_flags_q[FlagV] <= bus.alu_v;
            state              <= StResp;
          end
        end
        StResp: begin
          if (bus.rsp_ready) begin
            state <= StIdle;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

  // Gated by reset so every output reads 0 while reset is held.
  assign bus.cmd_ready  = (state == StIdle) && !reset;
  assign bus.rsp_valid  = (state == StResp);
  assign bus.busy       = (state != StIdle);
  assign bus.alu_a      = alu_a_q;
  assign bus.alu_b      = alu_b_q;
  assign bus.alu_op     = alu_op_q;
  assign bus.rsp_result = rsp_result_q;
  assign bus.rsp_flags  = rsp_flags_q;

endmodule

// File: tb/tb_alu4_cmd_seq.sv
// Randomized self-checking bench for alu4_cmd_seq; the bench itself acts as a stub alu4
// and keeps an array model of the register file and the expected alu4 drive.
module tb_alu4_cmd_seq;

  localparam int unsigned WIDTH  = 4;
  localparam int unsigned SETTLE = 3;

  logic clk;
  logic reset;

  alu4_cmd_seq_if #(.WIDTH(WIDTH)) bus ();

  alu4_cmd_seq #(
    .WIDTH (WIDTH),
    .SETTLE(SETTLE)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [3:0] rf_m [4];
  logic [3:0] exp_a;
  logic [3:0] exp_b;
  logic [2:0] exp_op;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 4; i++) rf_m[i] = 4'd0;
    exp_a  = 4'd0;
    exp_b  = 4'd0;
    exp_op = 3'd0;
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_ready"}, 32'(bus.cmd_ready), 32'd0);
    check_eq({tag, "_valid"}, 32'(bus.rsp_valid), 32'd0);
    check_eq({tag, "_busy"}, 32'(bus.busy), 32'd0);
    check_eq({tag, "_outs"}, {8'd0, bus.alu_a, bus.alu_b, 1'b0, bus.alu_op,
                              bus.rsp_result, bus.rsp_flags}, 32'd0);
  endtask

  // One complete command: issue, track latency, stall the response, then handshake.
  task automatic run_cmd(input bit load, input logic [2:0] op, input logic [1:0] rd,
                         input logic [1:0] ra, input logic [1:0] rb, input bit imm_en,
                         input logic [3:0] imm, input logic [3:0] res,
                         input logic [3:0] flg, input int stall);
    int edges;
    int lat;
    logic [3:0] exp_res;
    logic [3:0] exp_flg;
    @(negedge clk);
    check_eq("idle_ready", 32'(bus.cmd_ready), 32'd1);
    check_eq("idle_busy", 32'(bus.busy), 32'd0);
    bus.cmd_valid  = 1'b1;
    bus.cmd_load   = load;
    bus.cmd_op     = op;
    bus.cmd_rd     = rd;
    bus.cmd_ra     = ra;
    bus.cmd_rb     = rb;
    bus.cmd_imm_en = imm_en;
    bus.cmd_imm    = imm;
    bus.alu_result = res;
    {bus.alu_c, bus.alu_n, bus.alu_z, bus.alu_v} = flg;
    if (load) begin
      exp_res = imm;
      exp_flg = 4'd0;
      lat     = 1;
    end else begin
      exp_a   = rf_m[ra];
      exp_b   = imm_en ? imm : rf_m[rb];
      exp_op  = op;
      exp_res = res;
      exp_flg = flg;
      lat     = SETTLE + 1;
    end
    @(posedge clk);
    edges = 1;
    @(negedge clk);
    // cmd_valid stays high: a second pending command must not be taken early.
    while (!bus.rsp_valid && edges < 40) begin
      check_eq("issue_alu", {20'd0, bus.alu_a, bus.alu_b, 1'b0, bus.alu_op},
               {20'd0, exp_a, exp_b, 1'b0, exp_op});
      check_eq("issue_ready", 32'(bus.cmd_ready), 32'd0);
      check_eq("issue_busy", 32'(bus.busy), 32'd1);
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    check_eq("latency", 32'(edges), 32'(lat));
    check_eq("rsp_result", 32'(bus.rsp_result), 32'(exp_res));
    check_eq("rsp_flags", 32'(bus.rsp_flags), 32'(exp_flg));
    check_eq("resp_alu_hold", {20'd0, bus.alu_a, bus.alu_b, 1'b0, bus.alu_op},
             {20'd0, exp_a, exp_b, 1'b0, exp_op});
    bus.alu_result = ~res;
    for (int i = 0; i < stall; i++) begin
      @(posedge clk);
      @(negedge clk);
      check_eq("stall_valid", 32'(bus.rsp_valid), 32'd1);
      check_eq("stall_ready", 32'(bus.cmd_ready), 32'd0);
      check_eq("stall_rsp", {24'd0, bus.rsp_result, bus.rsp_flags}, {24'd0, exp_res, exp_flg});
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    bus.cmd_valid = 1'b0;
    check_eq("post_valid", 32'(bus.rsp_valid), 32'd0);
    check_eq("post_ready", 32'(bus.cmd_ready), 32'd1);
    rf_m[rd] = exp_res;
  endtask

  task automatic reset_mid(input bit in_resp);
    @(negedge clk);
    bus.cmd_valid  = 1'b1;
    bus.cmd_load   = 1'b0;
    bus.cmd_op     = 3'($urandom);
    bus.cmd_rd     = 2'($urandom);
    bus.cmd_ra     = 2'($urandom);
    bus.cmd_rb     = 2'($urandom);
    bus.cmd_imm_en = 1'b1;
    bus.cmd_imm    = 4'hf;
    bus.alu_result = 4'($urandom_range(1, 15));
    {bus.alu_c, bus.alu_n, bus.alu_z, bus.alu_v} = 4'hf;
    @(posedge clk);
    if (in_resp) repeat (SETTLE) @(posedge clk);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    check_eq("pre_rst_valid", 32'(bus.rsp_valid), 32'(in_resp));
    #2 reset = 1'b1;
    #1 check_all_zero(in_resp ? "rst_resp" : "rst_issue");
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_eq("rel_ready", 32'(bus.cmd_ready), 32'd1);
    check_eq("rel_busy", 32'(bus.busy), 32'd0);
    model_clear();
    run_cmd(1'b0, 3'd2, 2'd0, 2'd1, 2'd2, 1'b0, 4'd0, 4'd9, 4'd1, 0);
    run_cmd(1'b0, 3'd3, 2'd1, 2'd3, 2'd0, 1'b0, 4'd0, 4'd6, 4'd2, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    bus.cmd_valid = 1'b0; bus.cmd_load = 1'b0; bus.cmd_op = 3'd0; bus.cmd_rd = 2'd0;
    bus.cmd_ra = 2'd0; bus.cmd_rb = 2'd0; bus.cmd_imm_en = 1'b0; bus.cmd_imm = 4'd0;
    bus.alu_result = 4'd0; bus.alu_c = 1'b0; bus.alu_n = 1'b0; bus.alu_z = 1'b0;
    bus.alu_v = 1'b0; bus.rsp_ready = 1'b0;
    model_clear();
    reset = 1'b1;
    #3 check_all_zero("reset");
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_eq("rel0_ready", 32'(bus.cmd_ready), 32'd1);
    check_eq("rel0_busy", 32'(bus.busy), 32'd0);

    // Load, then ALU op reading it with an immediate B operand.
    run_cmd(1'b1, 3'd0, 2'd1, 2'd0, 2'd0, 1'b0, 4'b1100, 4'd0, 4'd0, 0);
    run_cmd(1'b0, 3'b001, 2'd3, 2'd1, 2'd0, 1'b1, 4'b0011, 4'b1111, 4'b0101, 0);
    // Captured value must have reached rf[3].
    run_cmd(1'b0, 3'd4, 2'd0, 2'd3, 2'd1, 1'b0, 4'd0, 4'd7, 4'd8, 0);
    // Backpressure.
    run_cmd(1'b0, 3'd5, 2'd2, 2'd1, 2'd3, 1'b0, 4'd0, 4'd3, 4'd4, 5);
    // Aliasing ra=rb=rd.
    run_cmd(1'b1, 3'd0, 2'd2, 2'd0, 2'd0, 1'b0, 4'b0101, 4'd0, 4'd0, 0);
    run_cmd(1'b0, 3'd6, 2'd2, 2'd2, 2'd2, 1'b0, 4'd0, 4'b1010, 4'b0010, 0);
    run_cmd(1'b0, 3'd7, 2'd0, 2'd2, 2'd2, 1'b0, 4'd0, 4'd1, 4'd0, 0);

    for (int n = 0; n < 40; n++) begin
      run_cmd(($urandom_range(0, 2) == 0), 3'($urandom), 2'($urandom), 2'($urandom),
              2'($urandom), 1'($urandom), 4'($urandom), 4'($urandom), 4'($urandom),
              int'($urandom_range(0, 3)));
    end

    reset_mid(1'b0);
    reset_mid(1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
